// File: rtl/serial_recv_if.sv
// serial_recv link bundle: captured bit pairs in,
// deserialized words and lock status out.
interface serial_recv_if;
  logic [1:0]  DIN;
  logic        RELOCK;
  logic [63:0] DOUT;
  logic        DOUT_VALID;
  logic        LOCKED;
  logic        SLIP;
  logic [7:0]  LOCK_FAILS;

  modport master (
    output DIN, RELOCK,
    input  DOUT, DOUT_VALID, LOCKED,
    input  SLIP, LOCK_FAILS
  );

  modport slave (
    input  DIN, RELOCK,
    output DOUT, DOUT_VALID, LOCKED,
    output SLIP, LOCK_FAILS
  );
endinterface

// File: rtl/serial_recv.sv
// serial_recv: 2-bit/cycle deserializer that hunts a sync
// word at either bit phase, verifies it, then emits 64-bit words.
module serial_recv #(
  parameter logic [63:0] SYNC_WORD = 64'hF0E1_D2C3_B4A5_9687,
  parameter int unsigned N_VERIFY  = 4
) (
  input  logic          CLKS,
  input  logic          RSTXS,
  serial_recv_if.slave  bus
);
  localparam int unsigned VW = $clog2(N_VERIFY + 1);

  typedef enum logic [1:0] {
    S_HUNT,
    S_VERIFY,
    S_LOCKED
  } state_e;

  state_e        state_q, state_d;
  logic [62:0]   hist_q, hist_d;
  logic [4:0]    phase_q, phase_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          slip_q, slip_d;
  logic [7:0]    fails_q, fails_d;
  logic [63:0]   dout_q, dout_d;
  logic          valid_q, valid_d;

  // Only 65 history bits are ever observable: the odd
  // candidate reaches one bit past the even one.
  logic [64:0]   win;
  logic [63:0]   even_c, odd_c, sel_c;
  logic          even_hit, odd_hit, sel_hit;
  logic          boundary;
  logic [VW-1:0] vcnt_inc;

  assign win      = {hist_q, bus.DIN};
  assign even_c   = win[63:0];
  assign odd_c    = win[64:1];
  assign sel_c    = slip_q ? odd_c : even_c;
  assign even_hit = (even_c == SYNC_WORD);
  assign odd_hit  = (odd_c == SYNC_WORD);
  assign sel_hit  = (sel_c == SYNC_WORD);
  assign boundary = (phase_q == 5'd0);
  assign vcnt_inc = vcnt_q + VW'(1);

  // State and datapath registers
  always_ff @(posedge CLKS) begin
    if (!RSTXS) begin
      state_q <= S_HUNT;
      hist_q  <= '0;
      phase_q <= '0;
      vcnt_q  <= '0;
      slip_q  <= 1'b0;
      fails_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      phase_q <= phase_d;
      vcnt_q  <= vcnt_d;
      slip_q  <= slip_d;
      fails_q <= fails_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  // Next state: hunt both phases, verify at frame
  // boundaries, deliver words once locked
  always_comb begin
    state_d = state_q;
    hist_d  = win[62:0];
    phase_d = phase_q + 5'd1;
    vcnt_d  = vcnt_q;
    slip_d  = slip_q;
    fails_d = fails_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    if (bus.RELOCK) begin
      state_d = S_HUNT;
    end else begin
      unique case (state_q)
        S_HUNT: begin
          if (even_hit || odd_hit) begin
            slip_d  = !even_hit;
            phase_d = 5'd1;
            vcnt_d  = '0;
            state_d = S_VERIFY;
          end
        end
        S_VERIFY: begin
          if (boundary) begin
            if (sel_hit) begin
              vcnt_d = vcnt_inc;
              if (vcnt_inc == VW'(N_VERIFY)) begin
                state_d = S_LOCKED;
              end
            end else begin
              state_d = S_HUNT;
              vcnt_d  = '0;
              if (fails_q != 8'hFF) begin
                fails_d = fails_q + 8'd1;
              end
            end
          end
        end
        S_LOCKED: begin
          if (boundary) begin
            dout_d  = sel_c;
            valid_d = 1'b1;
          end
        end
        default: state_d = S_HUNT;
      endcase
    end
  end

  // Outputs straight from registers
  always_comb begin
    bus.DOUT       = dout_q;
    bus.DOUT_VALID = valid_q;
    bus.LOCKED     = (state_q == S_LOCKED);
    bus.SLIP       = slip_q;
    bus.LOCK_FAILS = fails_q;
  end
endmodule

// File: tb/tb_serial_recv.sv
// tb_serial_recv: directed table, corner sequences and a
// random stream checked against a bit-queue reference model.
module tb_serial_recv;
  localparam logic [63:0] SYNC = 64'hF0E1_D2C3_B4A5_9687;
  localparam logic [63:0] PAY  = 64'hDEADBEEF_CAFEF00D;
  localparam int          NV   = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  serial_recv_if bus();

  serial_recv dut (
    .CLKS  (clk),
    .RSTXS (rstn),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic relock_r;
  bit   rl_rand;
  bit   txq[$];

  int          nstrobe;
  logic [63:0] first_dout;
  int          first_sc, last_sc;

  // reference model: received bit history as a queue, and
  // frame boundaries as absolute cycle numbers
  bit          mq[$];
  int          m_st;
  int          m_good;
  logic        m_slip;
  int          m_fails;
  logic [63:0] m_dout;
  logic        m_valid;
  int          cyc = 0;
  int          m_nb = 0;

  typedef struct {
    int          lead;
    int          nsync;
    int          bad_at;
    logic [63:0] pay;
    bit          e_lock;
    bit          e_slip;
    int          e_fails;
    logic [63:0] e_dout;
    int          e_strb;
  } vec_t;

  vec_t tv[6];

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] cand(int skip);
    logic [63:0] w;
    int base;
    w = '0;
    base = mq.size() - 64 - skip;
    for (int i = 0; i < 64; i++) w = {w[62:0], mq[base+i]};
    return w;
  endfunction

  task automatic model_edge(logic rn, logic [1:0] d,
                            logic rl);
    logic [63:0] e, o, w;
    bit bnd;
    cyc++;
    if (!rn) begin
      mq.delete();
      repeat (66) mq.push_back(1'b0);
      m_st = 0; m_good = 0; m_slip = 0;
      m_fails = 0; m_dout = '0; m_valid = 0;
      return;
    end
    mq.push_back(d[1]);
    mq.push_back(d[0]);
    while (mq.size() > 70) void'(mq.pop_front());
    e = cand(0);
    o = cand(1);
    w = m_slip ? o : e;
    bnd = (m_st != 0) && (cyc == m_nb);
    if (bnd) m_nb += 32;
    m_valid = 0;
    if (rl) begin
      m_st = 0;
    end else if (m_st == 0) begin
      if (e == SYNC || o == SYNC) begin
        m_slip = (e != SYNC);
        m_st = 1;
        m_good = 0;
        m_nb = cyc + 32;
      end
    end else if (bnd) begin
      if (m_st == 1) begin
        if (w == SYNC) begin
          m_good++;
          if (m_good == NV) m_st = 2;
        end else begin
          m_st = 0;
          m_good = 0;
          if (m_fails < 255) m_fails++;
        end
      end else begin
        m_dout = w;
        m_valid = 1;
      end
    end
  endtask

  task automatic step(logic [1:0] d);
    bus.DIN = d;
    bus.RELOCK = rl_rand ? ($urandom_range(0, 199) == 0)
                         : relock_r;
    @(posedge clk);
    model_edge(rstn, d, bus.RELOCK);
    #1;
    chk("locked", 64'(bus.LOCKED), 64'(m_st == 2));
    chk("valid", 64'(bus.DOUT_VALID), 64'(m_valid));
    chk("slip", 64'(bus.SLIP), 64'(m_slip));
    chk("fails", 64'(bus.LOCK_FAILS), 64'(m_fails));
    chk("dout", bus.DOUT, m_dout);
    if (bus.DOUT_VALID === 1'b1) begin
      if (nstrobe == 0) begin
        first_dout = bus.DOUT;
        first_sc = cyc;
      end
      last_sc = cyc;
      nstrobe++;
    end
  endtask

  task automatic pump(bit rl_last);
    while (txq.size() >= 2) begin
      bit last;
      logic [1:0] d;
      last = (txq.size() < 4);
      d[1] = txq.pop_front();
      d[0] = txq.pop_front();
      if (rl_last && last) relock_r = 1'b1;
      step(d);
      if (rl_last && last) relock_r = 1'b0;
    end
  endtask

  task automatic push_word(logic [63:0] w);
    for (int i = 63; i >= 0; i--) txq.push_back(w[i]);
  endtask

  task automatic send(logic [63:0] w, bit rl_last);
    push_word(w);
    pump(rl_last);
  endtask

  task automatic do_reset();
    txq.delete();
    rstn = 1'b0;
    relock_r = 1'b0;
    repeat (3) step(2'($urandom));
    chk("rst_dout", bus.DOUT, 64'h0);
    chk("rst_valid", 64'(bus.DOUT_VALID), 64'h0);
    chk("rst_locked", 64'(bus.LOCKED), 64'h0);
    chk("rst_slip", 64'(bus.SLIP), 64'h0);
    chk("rst_fails", 64'(bus.LOCK_FAILS), 64'h0);
    rstn = 1'b1;
    nstrobe = 0;
    first_dout = '0;
    first_sc = 0;
    last_sc = 0;
  endtask

  task automatic run_vec(vec_t v);
    do_reset();
    repeat (v.lead) txq.push_back(1'b0);
    for (int i = 0; i < v.nsync; i++)
      send((i == v.bad_at) ? (SYNC ^ 64'd1) : SYNC, 1'b0);
    send(v.pay, 1'b0);
    if (txq.size() == 1) begin
      txq.push_back(1'b0);
      pump(1'b0);
    end
    repeat (2) step(2'b00);
    chk("v_locked", 64'(bus.LOCKED), 64'(v.e_lock));
    chk("v_slip", 64'(bus.SLIP), 64'(v.e_slip));
    chk("v_fails", 64'(bus.LOCK_FAILS), 64'(v.e_fails));
    chk("v_first_dout", first_dout, v.e_dout);
    chk("v_strobes", 64'(nstrobe), 64'(v.e_strb));
    if (nstrobe > 1)
      chk("v_spacing", 64'(last_sc - first_sc),
          64'(32 * (nstrobe - 1)));
  endtask

  initial begin
    tv[0] = '{0, 5, -1, PAY, 1, 0, 0, PAY, 1};
    tv[1] = '{1, 5, -1, PAY, 1, 1, 0, PAY, 1};
    tv[2] = '{0, 3, 2, PAY, 0, 0, 1, 64'h0, 0};
    tv[3] = '{0, 4, -1, PAY, 0, 0, 1, 64'h0, 0};
    tv[4] = '{1, 8, -1, PAY, 1, 1, 0, SYNC, 4};
    tv[5] = '{0, 7, 1, PAY, 1, 0, 1, PAY, 1};

    rl_rand = 1'b0;
    relock_r = 1'b0;
    rstn = 1'b0;
    bus.DIN = 2'b00;
    bus.RELOCK = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(tv[i]);

    // relock pulse on a delivery boundary, then held relock
    do_reset();
    repeat (5) send(SYNC, 1'b0);
    send(PAY, 1'b0);
    chk("t5_pre_valid", 64'(bus.DOUT_VALID), 64'h1);
    chk("t5_pre_dout", bus.DOUT, PAY);
    send(64'h0123_4567_89AB_CDEF, 1'b1);
    chk("t5_rl_locked", 64'(bus.LOCKED), 64'h0);
    chk("t5_rl_valid", 64'(bus.DOUT_VALID), 64'h0);
    chk("t5_rl_dout", bus.DOUT, PAY);
    relock_r = 1'b1;
    repeat (6) send(SYNC, 1'b0);
    chk("t5_hold_locked", 64'(bus.LOCKED), 64'h0);
    relock_r = 1'b0;
    repeat (5) send(SYNC, 1'b0);
    chk("t5_relocked", 64'(bus.LOCKED), 64'h1);
    send(~PAY, 1'b0);
    chk("t5_post_valid", 64'(bus.DOUT_VALID), 64'h1);
    chk("t5_post_dout", bus.DOUT, ~PAY);
    chk("t5_fails", 64'(bus.LOCK_FAILS), 64'h0);

    // verify-failure counter saturation
    do_reset();
    repeat (255) begin
      send(SYNC, 1'b0);
      send(SYNC ^ 64'd1, 1'b0);
    end
    chk("t6_fails_255", 64'(bus.LOCK_FAILS), 64'd255);
    repeat (45) begin
      send(SYNC, 1'b0);
      send(SYNC ^ 64'd1, 1'b0);
    end
    chk("t6_fails_sat", 64'(bus.LOCK_FAILS), 64'd255);
    chk("t6_locked", 64'(bus.LOCKED), 64'h0);
    do_reset();

    // random stream with sporadic slips and relocks
    for (int blk = 0; blk < 3; blk++) begin
      do_reset();
      rl_rand = 1'b1;
      for (int k = 0; k < 100; k++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 5)
          push_word(SYNC);
        else if (r < 7)
          push_word(SYNC ^ (64'd1 << $urandom_range(0, 63)));
        else
          push_word({$urandom, $urandom});
        if ($urandom_range(0, 19) == 0)
          txq.push_back(1'($urandom));
        pump(1'b0);
      end
      rl_rand = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
